uart_bram_loader: RTL and testbench

- Boot-time loader: polls an AXI4-Lite UART (RX FIFO plus status register) and streams the received bytes into a BRAM port.
- Sits between the UART-Lite slave and the instruction/data BRAM, ahead of core release.
- Generalised over word width, byte order and load window.
- Adds a length header, error reporting, re-arm via start, and a done handshake to the core.

---
 rtl/uart_bram_loader_if.sv | 35 +++
 rtl/uart_bram_loader.sv | 168 ++++++++++++++++
 tb/tb_uart_bram_loader.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bram_loader_if.sv
// AXI4-Lite read channels plus BRAM write port between the boot loader and its peers.
// Valid/ready: a beat transfers on a rising clk edge where valid and ready are both 1;
// the source holds valid and its payload stable until that edge and never withdraws it.
interface uart_bram_loader_if #(
    parameter int ADDR_W = 15,
    parameter int WORD_W = 32
);
    localparam int BPW = WORD_W / 8;

    logic              axi_arvalid;
    logic              axi_arready;
    logic [31:0]       axi_araddr;
    logic [2:0]        axi_arprot;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [31:0]       axi_rdata;
    logic [1:0]        axi_rresp;

    logic [ADDR_W-1:0] bram_addr;
    logic [WORD_W-1:0] bram_wrdata;
    logic              bram_en;
    logic [BPW-1:0]    bram_we;

    modport master (
        output axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        input  axi_arready, axi_rvalid, axi_rdata, axi_rresp,
        output bram_addr, bram_wrdata, bram_en, bram_we
    );

    modport slave (
        input  axi_arvalid, axi_araddr, axi_arprot, axi_rready,
        output axi_arready, axi_rvalid, axi_rdata, axi_rresp,
        input  bram_addr, bram_wrdata, bram_en, bram_we
    );
endinterface

// File: rtl/uart_bram_loader.sv
// Boot loader: polls a UART-Lite over AXI4-Lite reads, takes a 4-byte big-endian word
// count header, then packs the payload into BRAM words starting at OFFSET_ADDR.
module uart_bram_loader #(
    parameter int          ADDR_W        = 15,
    parameter int          WORD_W        = 32,
    parameter int          OFFSET_ADDR   = 0,
    parameter int          HIGH_ADDR     = 16383,
    parameter bit          BIG_ENDIAN    = 1'b1,
    parameter logic [31:0] RX_FIFO_ADDR  = 32'h0,
    parameter logic [31:0] STAT_REG_ADDR = 32'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] word_count,
    output logic [2:0]  dbg_state,
    uart_bram_loader_if.master bus
);
    localparam int          BPW = WORD_W / 8;
    localparam logic [32:0] CAP = 33'(HIGH_ADDR - OFFSET_ADDR + 1);

    typedef enum logic [2:0] {
        IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, BRAM_WR, DONE, ERR
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        byte_cnt;
    logic              payload;
    logic [23:0]       hdr;
    logic [31:0]       idx;
    logic [WORD_W-1:0] word_asm;

    logic [7:0]        rx_byte;
    logic [31:0]       hdr_full;
    logic              armed;
    logic              last_hdr_byte;
    logic              last_word_byte;
    logic              rx_ok;
    logic              unused_rdata;

    assign rx_byte        = bus.axi_rdata[7:0];
    assign hdr_full       = {hdr, rx_byte};
    assign armed          = start && (state == IDLE || state == DONE || state == ERR);
    assign last_hdr_byte  = !payload && (byte_cnt == 8'd3);
    assign last_word_byte = payload && (byte_cnt == 8'(BPW - 1));
    assign rx_ok          = bus.axi_rvalid && (bus.axi_rresp == 2'b00);
    assign unused_rdata   = ^bus.axi_rdata[31:8];
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        busy            = 1'b0;
        done            = 1'b0;
        error           = 1'b0;
        bus.axi_arvalid = 1'b0;
        bus.axi_araddr  = '0;
        bus.axi_arprot  = '0;
        bus.axi_rready  = 1'b0;
        bus.bram_en     = 1'b0;
        bus.bram_we     = '0;
        bus.bram_addr   = '0;
        bus.bram_wrdata = '0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STAT_AR;
            end
            STAT_AR: begin
                busy            = 1'b1;
                bus.axi_arvalid = 1'b1;
                bus.axi_araddr  = STAT_REG_ADDR;
                if (bus.axi_arready) state_nxt = STAT_R;
            end
            STAT_R: begin
                busy           = 1'b1;
                bus.axi_rready = 1'b1;
                if (bus.axi_rvalid) begin
                    if (bus.axi_rresp != 2'b00) state_nxt = ERR;
                    else if (bus.axi_rdata[0])  state_nxt = DATA_AR;
                    else                        state_nxt = STAT_AR;
                end
            end
            DATA_AR: begin
                busy            = 1'b1;
                bus.axi_arvalid = 1'b1;
                bus.axi_araddr  = RX_FIFO_ADDR;
                if (bus.axi_arready) state_nxt = DATA_R;
            end
            DATA_R: begin
                busy           = 1'b1;
                bus.axi_rready = 1'b1;
                if (bus.axi_rvalid) begin
                    if (bus.axi_rresp != 2'b00) state_nxt = ERR;
                    else if (last_hdr_byte) begin
                        // An empty image completes at once; an oversize one never touches BRAM.
                        if (hdr_full == 32'd0)          state_nxt = DONE;
                        else if ({1'b0, hdr_full} > CAP) state_nxt = ERR;
                        else                            state_nxt = STAT_AR;
                    end
                    else if (last_word_byte) state_nxt = BRAM_WR;
                    else                     state_nxt = STAT_AR;
                end
            end
            BRAM_WR: begin
                busy            = 1'b1;
                bus.bram_en     = 1'b1;
                bus.bram_we     = '1;
                bus.bram_addr   = ADDR_W'(32'(OFFSET_ADDR) + idx);
                bus.bram_wrdata = word_asm;
                state_nxt       = (idx + 32'd1 == word_count) ? DONE : STAT_AR;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = STAT_AR;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = STAT_AR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            payload    <= 1'b0;
            hdr        <= '0;
            idx        <= '0;
            word_asm   <= '0;
            word_count <= '0;
        end
        else if (armed) begin
            byte_cnt <= '0;
            payload  <= 1'b0;
            idx      <= '0;
        end
        else if (state == DATA_R && rx_ok) begin
            if (!payload) begin
                hdr <= hdr_full[23:0];
                if (last_hdr_byte) begin
                    word_count <= hdr_full;
                    payload    <= 1'b1;
                    byte_cnt   <= '0;
                end
                else begin
                    byte_cnt <= byte_cnt + 8'd1;
                end
            end
            else begin
                // Big-endian shifts bytes in at the bottom; little-endian at the top.
                if (BIG_ENDIAN) word_asm <= WORD_W'({word_asm, rx_byte});
                else            word_asm <= WORD_W'({rx_byte, word_asm} >> 8);
                byte_cnt <= last_word_byte ? 8'd0 : byte_cnt + 8'd1;
            end
        end
        else if (state == BRAM_WR) begin
            idx <= idx + 32'd1;
        end
    end
endmodule

// File: tb/tb_uart_bram_loader.sv
// Bench for uart_bram_loader: a big-endian and a little-endian loader share one scripted
// UART slave and are checked against a byte-stream reference model.
module tb_uart_bram_loader;
    localparam int          ADDR_W = 15;
    localparam int          WORD_W = 32;
    localparam int          OFFSET = 16;
    localparam int          CAP    = 16384;
    localparam logic [31:0] FIFO_A = 32'h0;
    localparam logic [31:0] STAT_A = 32'h8;

    logic clk, rst, start;
    logic arready, rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    logic busy_be, done_be, error_be, busy_le, done_le, error_le;
    logic [31:0] wc_be, wc_le;
    logic [2:0]  st_be, st_le;

    uart_bram_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus_be ();
    uart_bram_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus_le ();

    assign bus_be.axi_arready = arready;
    assign bus_be.axi_rvalid  = rvalid;
    assign bus_be.axi_rdata   = rdata;
    assign bus_be.axi_rresp   = rresp;
    assign bus_le.axi_arready = arready;
    assign bus_le.axi_rvalid  = rvalid;
    assign bus_le.axi_rdata   = rdata;
    assign bus_le.axi_rresp   = rresp;

    uart_bram_loader #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFFSET_ADDR(OFFSET), .HIGH_ADDR(OFFSET + CAP - 1),
        .BIG_ENDIAN(1'b1), .RX_FIFO_ADDR(FIFO_A), .STAT_REG_ADDR(STAT_A)
    ) dut_be (
        .clk(clk), .rst(rst), .start(start), .busy(busy_be), .done(done_be), .error(error_be),
        .word_count(wc_be), .dbg_state(st_be), .bus(bus_be)
    );

    uart_bram_loader #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFFSET_ADDR(OFFSET), .HIGH_ADDR(OFFSET + CAP - 1),
        .BIG_ENDIAN(1'b0), .RX_FIFO_ADDR(FIFO_A), .STAT_REG_ADDR(STAT_A)
    ) dut_le (
        .clk(clk), .rst(rst), .start(start), .busy(busy_le), .done(done_le), .error(error_le),
        .word_count(wc_le), .dbg_state(st_le), .bus(bus_le)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0]  src[$];
    logic [7:0]  stream_q[$];
    logic [ADDR_W+63:0] exp_q[$];
    logic [ADDR_W+31:0] act_q0[$];
    logic [ADDR_W+31:0] act_q1[$];
    logic        exp_done, exp_err;
    logic [31:0] exp_wc;
    int proto_bad;
    int zero_polls, ar_delay, r_delay, err_idx, rst_idx;
    int fifo_idx, polls;
    bit abort;

    // Write capture and protocol watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus_be.bram_en) act_q0.push_back({bus_be.bram_addr, bus_be.bram_wrdata});
        if (bus_le.bram_en) act_q1.push_back({bus_le.bram_addr, bus_le.bram_wrdata});
        if ((bus_be.axi_arvalid && bus_be.axi_rready) || (bus_le.axi_arvalid && bus_le.axi_rready))
            proto_bad++;
        if ((bus_be.bram_en ? (bus_be.bram_we != 4'hF) : (bus_be.bram_we != 4'h0)) ||
            (bus_le.bram_en ? (bus_le.bram_we != 4'hF) : (bus_le.bram_we != 4'h0)))
            proto_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derive expected writes and final status from the byte stream.
    task automatic model_load(input int err_at);
        logic [31:0] n, wbe, wle;
        int k;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < 4; i++) if (i == err_at) begin exp_err = 1'b1; return; end
        n = {src[0], src[1], src[2], src[3]};
        exp_wc = n;
        if (n == 0) begin exp_done = 1'b1; return; end
        if (n > CAP) begin exp_err = 1'b1; return; end
        for (int w = 0; w < int'(n); w++) begin
            wbe = 0;
            wle = 0;
            for (int b = 0; b < 4; b++) begin
                k = 4 + 4 * w + b;
                if (k == err_at) begin exp_err = 1'b1; return; end
                wbe = wbe * 256 + 32'(src[k]);
                wle = wle + (32'(src[k]) << (8 * b));
            end
            exp_q.push_back({ADDR_W'(OFFSET + w), wbe, wle});
        end
        exp_done = 1'b1;
    endtask

    // UART slave: serve one AXI read (status or FIFO) with the configured stalls.
    task automatic serve_read();
        int w;
        logic [31:0] a, d;
        logic [1:0]  resp;
        bit do_rst;
        w = 0;
        do_rst = 0;
        resp = 2'b00;
        while (!bus_be.axi_arvalid && busy_be && w < 100) begin tick(); w++; end
        if (!busy_be) return;
        checks++;
        if (!bus_be.axi_arvalid) begin
            errors++;
            $display("FAIL arvalid_timeout arvalid=%0b required 1 within 100 cycles", bus_be.axi_arvalid);
            abort = 1;
            return;
        end
        a = bus_be.axi_araddr;
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            checks++;
            if (bus_be.axi_arvalid !== 1'b1 || bus_be.axi_araddr !== a) begin
                errors++;
                $display("FAIL ar_hold arvalid=%0b araddr=%h required 1 %h", bus_be.axi_arvalid, bus_be.axi_araddr, a);
            end
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < r_delay; i++) begin
            checks++;
            if (bus_be.axi_rready !== 1'b1 || bus_be.axi_arvalid !== 1'b0) begin
                errors++;
                $display("FAIL r_wait rready=%0b arvalid=%0b required 1 0", bus_be.axi_rready, bus_be.axi_arvalid);
            end
            tick();
        end
        d = $urandom();
        if (a == STAT_A) begin
            d[0] = (polls >= zero_polls);
            polls++;
        end
        else if (a == FIFO_A) begin
            checks++;
            if (stream_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow reads=%0d required at most %0d", fifo_idx + 1, src.size());
                d[7:0] = 8'h00;
            end
            else d[7:0] = stream_q.pop_front();
            if (fifo_idx == err_idx) resp = 2'b10;
            do_rst = (fifo_idx == rst_idx);
            fifo_idx++;
            polls = 0;
        end
        else begin
            checks++;
            errors++;
            $display("FAIL araddr_value araddr=%h required %h or %h", a, STAT_A, FIFO_A);
        end
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        if (do_rst) rst = 1'b1;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        if (do_rst) begin
            checks++;
            if ({busy_be, done_be, error_be, wc_be, bus_be.axi_arvalid, bus_be.axi_rready, bus_be.bram_en,
                 bus_be.bram_we, bus_be.bram_addr, bus_be.bram_wrdata, bus_be.axi_araddr} !== '0) begin
                errors++;
                $display("FAIL rst_outputs busy=%0b done=%0b err=%0b wc=%0d arvalid=%0b en=%0b required all 0",
                         busy_be, done_be, error_be, wc_be, bus_be.axi_arvalid, bus_be.bram_en);
            end
        end
    endtask

    task automatic run_load();
        int reads;
        stream_q = src;
        fifo_idx = 0;
        polls    = 0;
        abort    = 0;
        act_q0.delete();
        act_q1.delete();
        proto_bad = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        reads = 0;
        while (busy_be && !abort && reads < 3000) begin serve_read(); reads++; end
        checks++;
        if (busy_be) begin
            errors++;
            $display("FAIL load_timeout busy=%0b required 0 after %0d reads", busy_be, reads);
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy_be, done_be, error_be, wc_be, st_be, bus_be.axi_arvalid, bus_be.axi_araddr, bus_be.axi_arprot,
             bus_be.axi_rready, bus_be.bram_en, bus_be.bram_we, bus_be.bram_addr, bus_be.bram_wrdata} !== '0 ||
            {busy_le, done_le, error_le, wc_le, st_le, bus_le.axi_arvalid, bus_le.axi_rready, bus_le.bram_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy=%0b done=%0b err=%0b wc=%0d state=%0d arvalid=%0b required all 0",
                     busy_be, done_be, error_be, wc_be, st_be, bus_be.axi_arvalid);
        end
        rst = 1'b0;
        exp_wc = 0;
        tick();
    endtask

    task automatic load_directed(input int polls_n, input int ard, input int rd, input int err_at);
        logic [7:0] s[12] = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                              8'h01, 8'h02, 8'h03, 8'h04};
        src.delete();
        foreach (s[i]) src.push_back(s[i]);
        zero_polls = polls_n; ar_delay = ard; r_delay = rd; err_idx = err_at; rst_idx = -1;
        model_load(err_at);
        run_load();
    endtask

    task automatic test_endian();
        logic [ADDR_W+63:0] e;
        load_directed(0, 0, 0, -1);
        checks++;
        if (act_q0.size() != 2 || act_q1.size() != 2 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL endian_wr_count be=%0d le=%0d required 2", act_q0.size(), act_q1.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q0.size() && i < act_q1.size(); i++) begin
            e = exp_q[i];
            checks++;
            if (act_q0[i] !== {e[ADDR_W+63:64], e[63:32]} || act_q1[i] !== {e[ADDR_W+63:64], e[31:0]}) begin
                errors++;
                $display("FAIL endian_wr%0d be=%h le=%h required %h", i, act_q0[i], act_q1[i], e);
            end
        end
        checks++;
        if (act_q0.size() > 0 && act_q0[0] !== {15'h10, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL endian_first_word got=%h required %h", act_q0[0], {15'h10, 32'hDEADBEEF});
        end
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {3'b010, 32'd2} || {busy_le, done_le, error_le, wc_le} !== {3'b010, 32'd2}) begin
            errors++;
            $display("FAIL endian_status busy=%0b done=%0b err=%0b wc=%0d required 0 1 0 2", busy_be, done_be, error_be, wc_be);
        end
        checks++;
        if (proto_bad != 0) begin errors++; $display("FAIL endian_protocol bad=%0d required 0", proto_bad); end
    endtask

    task automatic test_stall();
        logic [ADDR_W+63:0] e;
        load_directed(5, 3, 2, -1);
        checks++;
        if (act_q0.size() != exp_q.size() || act_q1.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stall_wr_count be=%0d le=%0d required %0d", act_q0.size(), act_q1.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q0.size() && i < act_q1.size(); i++) begin
            e = exp_q[i];
            checks++;
            if (act_q0[i] !== {e[ADDR_W+63:64], e[63:32]} || act_q1[i] !== {e[ADDR_W+63:64], e[31:0]}) begin
                errors++;
                $display("FAIL stall_wr%0d be=%h le=%h required %h", i, act_q0[i], act_q1[i], e);
            end
        end
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {1'b0, exp_done, exp_err, exp_wc} || stream_q.size() != 0) begin
            errors++;
            $display("FAIL stall_status done=%0b err=%0b wc=%0d left=%0d required %0b %0b %0d 0",
                     done_be, error_be, wc_be, stream_q.size(), exp_done, exp_err, exp_wc);
        end
        checks++;
        if (proto_bad != 0) begin errors++; $display("FAIL stall_protocol bad=%0d required 0", proto_bad); end
    endtask

    task automatic test_oversize();
        logic [ADDR_W+63:0] e;
        src = '{8'h00, 8'h01, 8'h00, 8'h00};
        zero_polls = 1; ar_delay = 0; r_delay = 0; err_idx = -1; rst_idx = -1;
        model_load(-1);
        run_load();
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {3'b001, 32'd65536} || error_le !== 1'b1 ||
            act_q0.size() != 0 || act_q1.size() != 0) begin
            errors++;
            $display("FAIL oversize_status done=%0b err=%0b wc=%0d writes=%0d required 0 1 65536 0",
                     done_be, error_be, wc_be, act_q0.size());
        end
        src = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        model_load(-1);
        run_load();
        checks++;
        if (act_q0.size() != 1 || act_q1.size() != 1) begin
            errors++;
            $display("FAIL rearm_wr_count be=%0d le=%0d required 1", act_q0.size(), act_q1.size());
        end
        else begin
            e = exp_q[0];
            checks++;
            if (act_q0[0] !== {e[ADDR_W+63:64], e[63:32]} || act_q1[0] !== {e[ADDR_W+63:64], e[31:0]}) begin
                errors++;
                $display("FAIL rearm_wr be=%h le=%h required %h", act_q0[0], act_q1[0], e);
            end
        end
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {3'b010, 32'd1}) begin
            errors++;
            $display("FAIL rearm_status done=%0b err=%0b wc=%0d required 1 0 1", done_be, error_be, wc_be);
        end
    endtask

    task automatic test_rresp_error();
        load_directed(0, 1, 0, 6);
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {3'b001, 32'd2} || error_le !== 1'b1 ||
            act_q0.size() != 0 || act_q1.size() != 0) begin
            errors++;
            $display("FAIL rresp_status done=%0b err=%0b wc=%0d writes=%0d required 0 1 2 0",
                     done_be, error_be, wc_be, act_q0.size());
        end
        src = '{8'h00, 8'h00, 8'h00, 8'h00};
        err_idx = -1;
        model_load(-1);
        run_load();
        checks++;
        if ({busy_be, done_be, error_be, wc_be} !== {3'b010, 32'd0} || done_le !== 1'b1 ||
            act_q0.size() != 0 || act_q1.size() != 0) begin
            errors++;
            $display("FAIL empty_status done=%0b err=%0b wc=%0d writes=%0d required 1 0 0 0",
                     done_be, error_be, wc_be, act_q0.size());
        end
    endtask

    task automatic test_rst_abort();
        logic [ADDR_W+63:0] e;
        load_directed(0, 0, 0, -1);
        rst_idx = 7;
        run_load();
        checks++;
        if (act_q0.size() != 0 || act_q1.size() != 0 || busy_be !== 1'b0 || fifo_idx != 8) begin
            errors++;
            $display("FAIL abort_writes writes=%0d busy=%0b bytes=%0d required 0 0 8", act_q0.size(), busy_be, fifo_idx);
        end
        rst = 1'b0;
        rst_idx = -1;
        tick();
        exp_wc = 0;
        model_load(-1);
        run_load();
        checks++;
        if (act_q0.size() != exp_q.size() || act_q1.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reload_wr_count be=%0d le=%0d required %0d", act_q0.size(), act_q1.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q0.size() && i < act_q1.size(); i++) begin
            e = exp_q[i];
            checks++;
            if (act_q0[i] !== {e[ADDR_W+63:64], e[63:32]} || act_q1[i] !== {e[ADDR_W+63:64], e[31:0]}) begin
                errors++;
                $display("FAIL reload_wr%0d be=%h le=%h required %h", i, act_q0[i], act_q1[i], e);
            end
        end
    endtask

    task automatic test_random();
        logic [ADDR_W+63:0] e;
        int n;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(0, 4);
            src.delete();
            for (int i = 0; i < 4; i++) src.push_back(8'((n >> (8 * (3 - i))) & 8'hFF));
            for (int i = 0; i < 4 * n; i++) src.push_back(8'($urandom_range(0, 255)));
            zero_polls = $urandom_range(0, 2);
            ar_delay   = $urandom_range(0, 2);
            r_delay    = $urandom_range(0, 2);
            err_idx    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * n + 3) : -1;
            rst_idx    = -1;
            model_load(err_idx);
            run_load();
            checks++;
            if (act_q0.size() != exp_q.size() || act_q1.size() != exp_q.size()) begin
                errors++;
                $display("FAIL random%0d_wr_count be=%0d le=%0d required %0d", it, act_q0.size(), act_q1.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < act_q0.size() && i < act_q1.size(); i++) begin
                e = exp_q[i];
                checks++;
                if (act_q0[i] !== {e[ADDR_W+63:64], e[63:32]} || act_q1[i] !== {e[ADDR_W+63:64], e[31:0]}) begin
                    errors++;
                    $display("FAIL random%0d_wr%0d be=%h le=%h required %h", it, i, act_q0[i], act_q1[i], e);
                end
            end
            checks++;
            if ({busy_be, done_be, error_be, wc_be} !== {1'b0, exp_done, exp_err, exp_wc} ||
                {busy_le, done_le, error_le, wc_le} !== {1'b0, exp_done, exp_err, exp_wc}) begin
                errors++;
                $display("FAIL random%0d_status done=%0b err=%0b wc=%0d required %0b %0b %0d",
                         it, done_be, error_be, wc_be, exp_done, exp_err, exp_wc);
            end
            checks++;
            if (proto_bad != 0) begin errors++; $display("FAIL random%0d_protocol bad=%0d required 0", it, proto_bad); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        zero_polls = 0; ar_delay = 0; r_delay = 0; err_idx = -1; rst_idx = -1;
        fifo_idx = 0; polls = 0; proto_bad = 0; abort = 0;
        exp_done = 0; exp_err = 0; exp_wc = 0;
        test_reset();
        test_endian();
        test_stall();
        test_oversize();
        test_rresp_error();
        test_rst_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
